// File: rtl/sort_pkg.sv
// Shared types for the sort-result streaming logic.
package sort_pkg;

   // Streamer holds at most one vector: either empty or emitting it.
   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_e;

endpackage

// File: rtl/sort_lane_select.sv
// Picks one lane of a sorted vector by output rank, optionally reading from the top lane down.
module sort_lane_select #(
   parameter int SIZE    = 4,
   parameter int REVERSE = 0,
   parameter int DW      = 8,
   parameter int IW      = 4,
   parameter int RW      = $clog2(SIZE)
) (
   input  logic [SIZE-1:0][DW-1:0] data_i,
   input  logic [SIZE-1:0][IW-1:0] index_i,
   input  logic [RW-1:0]           rank_i,
   output logic [DW-1:0]           data_o,
   output logic [IW-1:0]           index_o
);

   logic [RW-1:0] lane;

   // SIZE is a power of two, so SIZE-1-rank is simply the bitwise complement of rank.
   always_comb begin
      lane    = (REVERSE != 0) ? ~rank_i : rank_i;
      data_o  = data_i[lane];
      index_o = index_i[lane];
   end

endmodule

// File: rtl/sorted_result_streamer.sv
// Captures one sorted vector from the bitonic network and streams its first COUNT entries in rank order.
module sorted_result_streamer
   import sort_pkg::*;
#(
   parameter int SIZE          = 4,
   parameter int COUNT         = 4,
   parameter int REVERSE       = 0,
   parameter int NETWORK_WIDTH = 16,
   parameter int INDEX_WIDTH   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [SIZE-1:0][NETWORK_WIDTH-1:0]   data_in,
   input  logic [SIZE-1:0][INDEX_WIDTH-1:0]     index_in,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [NETWORK_WIDTH-1:0]             data_out,
   output logic [INDEX_WIDTH-1:0]               index_out,
   output logic [$clog2(SIZE)-1:0]              out_rank,
   output logic                                 out_last,
   output logic                                 busy
);

   localparam int            RW        = $clog2(SIZE);
   localparam logic [RW-1:0] LAST_RANK = RW'(COUNT - 1);

   stream_state_e                       state_q, state_d;
   logic [RW-1:0]                       ptr_q, ptr_d;
   logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_q, data_d;
   logic [SIZE-1:0][INDEX_WIDTH-1:0]    index_q, index_d;

   logic                     streaming, capture, accept;
   logic [NETWORK_WIDTH-1:0] sel_data;
   logic [INDEX_WIDTH-1:0]   sel_index;

   sort_lane_select #(
      .SIZE    (SIZE),
      .REVERSE (REVERSE),
      .DW      (NETWORK_WIDTH),
      .IW      (INDEX_WIDTH),
      .RW      (RW)
   ) u_sel (
      .data_i  (data_q),
      .index_i (index_q),
      .rank_i  (ptr_q),
      .data_o  (sel_data),
      .index_o (sel_index)
   );

   assign streaming = (state_q == STREAM);
   assign out_valid = streaming;
   assign busy      = streaming;
   assign out_last  = streaming & (ptr_q == LAST_RANK);
   assign out_rank  = streaming ? ptr_q : '0;
   assign data_out  = streaming ? sel_data : '0;
   assign index_out = streaming ? sel_index : '0;

   // A new vector may land while idle, or on the edge that retires the final beat; flush blocks both.
   assign in_ready = ~flush & (~streaming | (out_ready & out_last));
   assign capture  = in_valid & in_ready;
   assign accept   = streaming & out_ready & ~flush;

   // Next state: flush wins, then beat advance, then capture (which overrides the last-beat return to IDLE).
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      index_d = index_q;
      if (flush) begin
         state_d = IDLE;
         ptr_d   = '0;
      end else begin
         if (accept) begin
            if (out_last) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + RW'(1);
            end
         end
         if (capture) begin
            data_d  = data_in;
            index_d = index_in;
            state_d = STREAM;
            ptr_d   = '0;
         end
      end
   end

   // State, rank pointer and the held vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         data_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         index_q <= index_d;
      end
   end

endmodule
